uart_rx: RTL and testbench

//  Serial receiver, the input stage of the UART path: 8N1 frames on rx become bytes for the UART controller's read path.
//  16x oversampling with a 3-sample majority vote at mid-bit; single-byte holding register with valid/ack handshake.

---
 rtl/uart_rx_pkg.sv | 26 ++
 rtl/uart_rx_tick.sv | 30 +++
 rtl/uart_rx.sv | 154 +++++++++++++++
 tb/tb_uart_rx.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
package uart_rx_pkg;

  typedef logic [7:0] uint8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } uart_rx_state_t;

  localparam int unsigned TICK_W = 4;
  localparam int unsigned BIT_W  = 3;

  // Tick positions within a bit: two early samples, then the vote tick.
  localparam logic [TICK_W-1:0] SAMP_A_TICK = TICK_W'(7);
  localparam logic [TICK_W-1:0] SAMP_B_TICK = TICK_W'(8);
  localparam logic [TICK_W-1:0] VOTE_TICK   = TICK_W'(9);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// Oversample tick generator; phase restarts from zero whenever en drops.
module uart_rx_tick #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned DIV = (CLK_HZ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;

  assign tick = en && (cnt_q == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: 16x oversampling, 3-sample majority vote, one-byte holding register.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  input  logic rd_ack_i,
  output uint8 rx_data_o,
  output logic rx_valid_o,
  output logic frame_err_o,
  output logic overrun_o,
  output logic busy_o
);

  logic              rx_meta_q, rxs_q;
  uart_rx_state_t    state_q;
  logic              busy_q;
  logic [TICK_W-1:0] tick_cnt_q;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic [1:0]        samp_q;
  uint8              shift_q;
  logic              deliver_q, stop_q;
  uint8              rx_data_q;
  logic              rx_valid_q, frame_err_q, overrun_q;
  logic              tick_c, vote_c, vote_tick_c;

  uart_rx_tick #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (busy_q),
    .tick(tick_c)
  );

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rxs_q     <= rx_meta_q;
    end
  end

  assign vote_c      = maj3(samp_q[0], samp_q[1], rxs_q);
  assign vote_tick_c = tick_c && (tick_cnt_q == VOTE_TICK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RX_IDLE;
      busy_q     <= 1'b0;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      samp_q     <= 2'b11;
      shift_q    <= '0;
      deliver_q  <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      deliver_q <= 1'b0;
      if (tick_c) begin
        tick_cnt_q <= tick_cnt_q + TICK_W'(1);
        if (tick_cnt_q == SAMP_A_TICK) samp_q[0] <= rxs_q;
        if (tick_cnt_q == SAMP_B_TICK) samp_q[1] <= rxs_q;
      end
      case (state_q)
        RX_IDLE: begin
          tick_cnt_q <= '0;
          if (!rxs_q) begin
            state_q <= RX_START;
            busy_q  <= 1'b1;
          end
        end
        RX_START: begin
          if (vote_tick_c) begin
            bit_cnt_q <= '0;
            if (vote_c) begin
              state_q <= RX_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= RX_DATA;
            end
          end
        end
        RX_DATA: begin
          if (vote_tick_c) begin
            shift_q   <= {vote_c, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q == BIT_W'(7)) state_q <= RX_STOP;
          end
        end
        RX_STOP: begin
          // Leave at mid-stop so the next start edge can be caught early.
          if (vote_tick_c) begin
            deliver_q <= 1'b1;
            stop_q    <= vote_c;
            state_q   <= vote_c ? RX_IDLE : RX_BREAK;
            busy_q    <= ~vote_c;
          end
        end
        RX_BREAK: begin
          if (rxs_q) begin
            state_q <= RX_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= RX_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Holding register: an ack in the delivery cycle frees the slot for the new byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (deliver_q && (!rx_valid_q || rd_ack_i)) begin
        rx_data_q   <= shift_q;
        frame_err_q <= ~stop_q;
      end
      if (deliver_q) begin
        rx_valid_q <= 1'b1;
      end else if (rd_ack_i) begin
        rx_valid_q <= 1'b0;
      end
      if (rx_valid_q && rd_ack_i) begin
        overrun_q <= 1'b0;
      end else if (deliver_q && rx_valid_q) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = rx_valid_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus random frames against a line-level decode model.
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int unsigned CLK_HZ = 100_000_000;
  localparam int unsigned BAUD   = 625_000;
  localparam int DIV   = 10;
  localparam int BIT   = 16 * DIV;
  localparam int FAST  = 157;
  localparam int SLOW  = 163;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b1;
  logic rd_ack = 1'b1;
  uint8 rx_data;
  logic rx_valid, frame_err, overrun, busy;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  int         got_cyc[$];

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_i       (rx),
    .rd_ack_i   (rd_ack),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .frame_err_o(frame_err),
    .overrun_o  (overrun),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Capture every byte the consumer takes.
  always @(negedge clk) begin
    if (!rst && rx_valid && rd_ack) begin
      got_q.push_back({frame_err, rx_data});
      got_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: the model decodes the 10-bit line pattern it puts on the wire.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int bt);
    logic [9:0] line;
    logic [7:0] dec;
    line = {stop, d, 1'b0};
    dec = '0;
    for (int i = 0; i < 8; i++) dec = dec + (8'(line[i+1]) << i);
    exp_q.push_back({~line[9], dec});
    for (int i = 0; i < 10; i++) begin
      rx = line[i];
      repeat (bt) @(negedge clk);
    end
  endtask

  task automatic idle(input int nbits);
    rx = 1'b1;
    repeat (nbits * BIT) @(negedge clk);
  endtask

  task automatic flush();
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic compare(input string tag);
    int n;
    chk($sformatf("%s count", tag), 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    flush();
  endtask

  initial begin
    int t0, delta, bt, gap;
    logic [7:0] d;
    logic stop;

    repeat (3) @(negedge clk);
    chk("rst rx_data", 32'(rx_data), 32'h0);
    chk("rst rx_valid", 32'(rx_valid), 32'h0);
    chk("rst frame_err", 32'(frame_err), 32'h0);
    chk("rst overrun", 32'(overrun), 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    rst = 1'b0;
    idle(1);

    // Single clean frame and delivery latency from mid-stop.
    t0 = cyc;
    send_frame(8'hA5, 1'b1, BIT);
    idle(1);
    if (got_cyc.size() > 0) begin
      delta = got_cyc[0] - (t0 + (19 * BIT) / 2);
      chk("t1 latency", 32'(delta >= 0 && delta <= 2 + 16 * DIV), 32'h1);
    end else begin
      chk("t1 latency", 32'h0, 32'h1);
    end
    compare("t1");

    // Bad stop bit followed by a held-low line.
    send_frame(8'h3C, 1'b0, BIT);
    repeat (3 * BIT) @(negedge clk);
    chk("t2 busy in break", 32'(busy), 32'h1);
    idle(2);
    chk("t2 busy after break", 32'(busy), 32'h0);
    compare("t2");

    // Glitch shorter than half a bit.
    rx = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    chk("t3 busy rise", 32'(busy), 32'h1);
    idle(2);
    chk("t3 busy fall", 32'(busy), 32'h0);
    chk("t3 no byte", 32'(got_q.size()), 32'h0);

    // Overrun with no consumer, then ack.
    rd_ack = 1'b0;
    send_frame(8'h11, 1'b1, BIT);
    idle(1);
    send_frame(8'h22, 1'b1, BIT);
    idle(1);
    chk("t4 valid", 32'(rx_valid), 32'h1);
    chk("t4 data", 32'(rx_data), 32'h11);
    chk("t4 frame_err", 32'(frame_err), 32'h0);
    chk("t4 overrun", 32'(overrun), 32'h1);
    rd_ack = 1'b1;
    @(negedge clk);
    chk("t4 valid after ack", 32'(rx_valid), 32'h0);
    chk("t4 overrun after ack", 32'(overrun), 32'h0);
    flush();

    // Back-to-back frames with the sender 2% fast, then 2% slow.
    send_frame(8'h00, 1'b1, FAST);
    send_frame(8'hFF, 1'b1, FAST);
    send_frame(8'h55, 1'b1, FAST);
    idle(1);
    send_frame(8'h00, 1'b1, SLOW);
    send_frame(8'hFF, 1'b1, SLOW);
    send_frame(8'h55, 1'b1, SLOW);
    idle(1);
    chk("t5 overrun", 32'(overrun), 32'h0);
    compare("t5");

    // Reset in the middle of data bit 4 clears a held byte too.
    rd_ack = 1'b0;
    send_frame(8'h5A, 1'b1, BIT);
    idle(1);
    chk("t6 held valid", 32'(rx_valid), 32'h1);
    chk("t6 held data", 32'(rx_data), 32'h5A);
    fork
      send_frame(8'hC3, 1'b1, BIT);
      begin
        repeat ((11 * BIT) / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6 rst rx_data", 32'(rx_data), 32'h0);
        chk("t6 rst rx_valid", 32'(rx_valid), 32'h0);
        chk("t6 rst frame_err", 32'(frame_err), 32'h0);
        chk("t6 rst overrun", 32'(overrun), 32'h0);
        chk("t6 rst busy", 32'(busy), 32'h0);
        rst = 1'b0;
        rd_ack = 1'b1;
      end
    join
    idle(6);
    flush();
    rd_ack = 1'b0;
    send_frame(8'h81, 1'b1, BIT);
    idle(1);
    chk("t6 valid", 32'(rx_valid), 32'h1);
    chk("t6 data", 32'(rx_data), 32'h81);
    chk("t6 frame_err", 32'(frame_err), 32'h0);
    rd_ack = 1'b1;
    @(negedge clk);
    flush();

    // Random frames, rates and gaps.
    for (int k = 0; k < 8; k++) begin
      d = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 2))
        0: bt = FAST;
        1: bt = SLOW;
        default: bt = BIT;
      endcase
      gap = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      send_frame(d, stop, bt);
      idle(gap);
    end
    idle(2);
    chk("rand overrun", 32'(overrun), 32'h0);
    compare("rand");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
